tx_timec_seq: RTL
=================

# tx_timec_seq

Sequencer for SpaceWire time-code transmission on the TX path, directly upstream of the combinational time-code data/strobe encoder. Captures a time-code request, builds the 14-bit time-code shift image, and steps the one-hot bit-position counter once per TX bit period. Registers the encoder's data/strobe outputs as the "last" line state fed back into the encoder. Reports pending/done status to the main TX state machine.

## Interface
Parameters:
- HDR, 6'b011100, fixed header placed in timecode_s[13:8] (ESC + time-code control bits, sent bit 12 down to 8)

Ports:
- pclk_tx  in  1  TX clock; all state changes on rising edge
- enable_tx  in  1  active-low synchronous reset (low = reset, sampled on pclk_tx)
- tickin_tx  in  1  time-code request, one-cycle pulse
- timein_control_flag_tx  in  8  time value captured with tickin_tx
- tx_bit_strobe  in  1  one-cycle pulse per TX bit period
- grant_timec  in  1  high while main TX FSM is in time-code state
- last_type_in  in  6  one-hot type of previous character (NULL/FCT/EOP/EEP/DATA/TIMEC)
- tx_dout_timec  in  1  data bit from encoder
- tx_sout_timec  in  1  strobe bit from encoder
- global_counter_transfer_time  out  14  one-hot bit position; 0 when not sending
- timecode_s  out  14  {HDR, captured time value}
- last_type_time  out  6  last_type_in frozen at send start
- last_tx_dout_timec  out  1  registered data line
- last_tx_sout_timec  out  1  registered strobe line
- last_timein_control_flag_tx  out  1  XOR of the 8 time bits of the last completed time code
- timec_pending  out  1  request captured, not yet completed
- timec_done  out  1  one-cycle pulse after final bit

## Operation
- States: IDLE, ARMED, SEND.
- IDLE: tickin_tx=1 -> latch timein_control_flag_tx into timecode_s[7:0], timec_pending=1, go ARMED.
- ARMED: on cycle with grant_timec=1 and tx_bit_strobe=1 -> counter=14'd1, last_type_time<=last_type_in, go SEND.
- SEND: each tx_bit_strobe -> last_tx_dout_timec<=tx_dout_timec, last_tx_sout_timec<=tx_sout_timec, counter<<=1. Strobe with counter=8192 -> counter=0, timec_pending=0, timec_done=1 next cycle, last_timein_control_flag_tx<=^timecode_s[7:0], go IDLE.
- Counter always one-hot or zero; never any other value.
- tickin_tx in ARMED or SEND: ignored; captured value unchanged.
- grant_timec dropping in SEND: sequence continues to completion (main FSM must not preempt).
- tickin_tx in same cycle as done transition: accepted; next state ARMED with new value.
- Outside SEND, last_tx_dout/sout hold value; main TX path owns line state then.

## Timing
- Reset values: counter 0, timecode_s {HDR,8'h00}, last_type_time 6'b000001, last_tx_dout_timec 0, last_tx_sout_timec 0, last_timein_control_flag_tx 0, timec_pending 0, timec_done 0, state IDLE.
- tickin_tx -> timec_pending high: 1 cycle.
- Send length: exactly 14 strobes from first counter load to counter=0.
- timec_done asserted exactly 1 cycle, the cycle after counter returns to 0.
- Reset mid-SEND: all outputs to reset values next edge; no done pulse.

## Configuration
- TX_TIMEC_OVERRUN_EN defined: adds output timec_overrun (1 bit, reset 0), set sticky when tickin_tx arrives in ARMED or SEND, cleared only by reset.
- Undefined: port absent; ignored ticks leave no trace.

## Test plan
- Reset with enable_tx=0 for 3 cycles -> all outputs at listed reset values.
- tickin_tx with value 8'hA5, grant_timec=1, strobes every 4 cycles -> counter walks 1,2,4..8192,0; timecode_s=14'h1CA5; done pulse once; last_timein_control_flag_tx=0.
- Value 8'h01 -> after done, last_timein_control_flag_tx=1.
- Encoder inputs forced dout=1, sout=0 -> last_tx_dout_timec=1, last_tx_sout_timec=0 after first strobe in SEND.
- Second tickin_tx (8'h3C) mid-SEND -> timecode_s stays 8'hA5 in low byte; with TX_TIMEC_OVERRUN_EN, timec_overrun=1.
- enable_tx low at counter=64 -> counter 0, pending 0, no timec_done.

Source files
------------

// File: rtl/tx_timec_seq_if.sv
// Time-code sequencer bus: request/strobe/grant inputs from the TX path and
// encoder feedback, plus shift image, bit position and status back out.
// When TX_TIMEC_OVERRUN_EN is defined the bus also carries timec_overrun.
interface tx_timec_seq_if;
    logic        tickin_tx;
    logic [7:0]  timein_control_flag_tx;
    logic        tx_bit_strobe;
    logic        grant_timec;
    logic [5:0]  last_type_in;
    logic        tx_dout_timec;
    logic        tx_sout_timec;
    logic [13:0] global_counter_transfer_time;
    logic [13:0] timecode_s;
    logic [5:0]  last_type_time;
    logic        last_tx_dout_timec;
    logic        last_tx_sout_timec;
    logic        last_timein_control_flag_tx;
    logic        timec_pending;
    logic        timec_done;
`ifdef TX_TIMEC_OVERRUN_EN
    logic        timec_overrun;
`endif

    // TX control side: issues requests and strobes, observes status.
    modport master (
`ifdef TX_TIMEC_OVERRUN_EN
        input  timec_overrun,
`endif
        output tickin_tx, timein_control_flag_tx, tx_bit_strobe, grant_timec,
               last_type_in, tx_dout_timec, tx_sout_timec,
        input  global_counter_transfer_time, timecode_s, last_type_time,
               last_tx_dout_timec, last_tx_sout_timec,
               last_timein_control_flag_tx, timec_pending, timec_done
    );

    // Sequencer side.
    modport slave (
`ifdef TX_TIMEC_OVERRUN_EN
        output timec_overrun,
`endif
        input  tickin_tx, timein_control_flag_tx, tx_bit_strobe, grant_timec,
               last_type_in, tx_dout_timec, tx_sout_timec,
        output global_counter_transfer_time, timecode_s, last_type_time,
               last_tx_dout_timec, last_tx_sout_timec,
               last_timein_control_flag_tx, timec_pending, timec_done
    );
endinterface

// File: rtl/tx_timec_seq.sv
// SpaceWire TX time-code sequencer. Captures a time-code request, exposes
// the 14-bit shift image {HDR, time}, walks a one-hot bit position once per
// TX bit period and registers the encoder's data/strobe as line state.
// Optional: define TX_TIMEC_OVERRUN_EN to add a sticky timec_overrun flag
// that records requests arriving while a time code is already in flight.
module tx_timec_seq #(
    parameter logic [5:0] HDR = 6'b011100
) (
    input logic           pclk_tx,
    input logic           enable_tx,
    tx_timec_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ARMED, SEND} state_t;

    state_t      state, state_nxt;
    logic        capture, start, step, finish, ignored_tick;
    logic [13:0] counter;
    logic [7:0]  time_value;
    logic [5:0]  last_type;
    logic        last_dout, last_sout, parity, pending, done;

    // State register; enable_tx low returns the sequencer to IDLE.
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge pclk_tx) begin
        if (!enable_tx) state <= IDLE;
        else            state <= state_nxt;
    end

    // Next-state decode and one-cycle datapath controls.
    // NOTE: every output of this block is defaulted first so no path leaves
    // a signal unassigned and no latch is inferred.
    always_comb begin
        state_nxt    = state;
        capture      = 1'b0;
        start        = 1'b0;
        step         = 1'b0;
        finish       = 1'b0;
        ignored_tick = 1'b0;
        case (state)
            IDLE: begin
                if (bus.tickin_tx) begin
                    capture   = 1'b1;
                    state_nxt = ARMED;
                end
            end
            ARMED: begin
                ignored_tick = bus.tickin_tx;
                if (bus.grant_timec && bus.tx_bit_strobe) begin
                    start     = 1'b1;
                    state_nxt = SEND;
                end
            end
            SEND: begin
                // Grant is not consulted here: once started, the code completes.
                if (bus.tx_bit_strobe) begin
                    step = 1'b1;
                    if (counter[13]) begin
                        finish = 1'b1;
                        // A request coinciding with completion is accepted.
                        if (bus.tickin_tx) begin
                            capture   = 1'b1;
                            state_nxt = ARMED;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end else begin
                        ignored_tick = bus.tickin_tx;
                    end
                end else begin
                    ignored_tick = bus.tickin_tx;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Capture, bit-position walk, line-state registers and status flags.
    always_ff @(posedge pclk_tx) begin
        if (!enable_tx) begin
            counter    <= '0;
            time_value <= '0;
            last_type  <= 6'b000001;
            last_dout  <= 1'b0;
            last_sout  <= 1'b0;
            parity     <= 1'b0;
            pending    <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= finish;
            if (capture) time_value <= bus.timein_control_flag_tx;
            if (start) begin
                counter   <= 14'd1;
                last_type <= bus.last_type_in;
            end
            if (step) begin
                last_dout <= bus.tx_dout_timec;
                last_sout <= bus.tx_sout_timec;
                counter   <= finish ? 14'd0 : {counter[12:0], 1'b0};
            end
            if (finish) begin
                parity  <= ^time_value;
                pending <= 1'b0;
            end
            // A new capture wins over completion in the same cycle.
            if (capture) pending <= 1'b1;
        end
    end

`ifdef TX_TIMEC_OVERRUN_EN
    logic overrun;

    // Sticky record of requests dropped while a time code was in flight.
    always_ff @(posedge pclk_tx) begin
        if (!enable_tx)        overrun <= 1'b0;
        else if (ignored_tick) overrun <= 1'b1;
    end

    assign bus.timec_overrun = overrun;
`endif

    assign bus.global_counter_transfer_time = counter;
    assign bus.timecode_s                   = {HDR, time_value};
    assign bus.last_type_time               = last_type;
    assign bus.last_tx_dout_timec           = last_dout;
    assign bus.last_tx_sout_timec           = last_sout;
    assign bus.last_timein_control_flag_tx  = parity;
    assign bus.timec_pending                = pending;
    assign bus.timec_done                   = done;
endmodule
